// File: rtl/serial_mult_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mult_pkg: shared state encoding and counter sizing for serial_mult_ctrl. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mult_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_ADD  = ST_ADD,
    S_DONE = ST_DONE,
    S_BAD  = 2'd3
  } state_e;

  // Index counters must hold the value N (one past the last operand bit).
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_mult_ctrl_if.sv
// ----------------------------------------------------------------------------
// serial_mult_ctrl_if: operand and result valid/ready handshakes. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface serial_mult_ctrl_if #(
  parameter int N = 16
);

  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a_in;
  logic [N-1:0]   b_in;
  logic           busy;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] p;

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, busy, out_valid, p
  );

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, busy, out_valid, p
  );

endinterface

`default_nettype wire

// File: rtl/serial_mult_ctrl_fulladder.sv
// ----------------------------------------------------------------------------
// fulladder: single-bit full-adder cell. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/serial_mult_ctrl.sv
// ----------------------------------------------------------------------------
// serial_mult_ctrl: bit-serial unsigned NxN multiplier driving one full adder. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module serial_mult_ctrl
  import mult_pkg::*;
#(
  parameter int N = 16
) (
  input  logic              clk,
  input  logic              rst,
  serial_mult_ctrl_if.slave bus
);

  localparam int CNT_W = cnt_w(N);
  localparam int IW    = (N > 1) ? $clog2(N) : 1;
  localparam int KW    = $clog2(2 * N);
  localparam logic [CNT_W-1:0] C_N   = CNT_W'(N);
  localparam logic [CNT_W-1:0] C_NM1 = CNT_W'(N - 1);

  state_e           state_q, state_d;
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic [2*N-1:0]   acc_q, acc_d;
  logic [2*N-1:0]   p_q, p_d;
  logic [CNT_W-1:0] i_q, i_d;
  logic [CNT_W-1:0] j_q, j_d;
  logic             carry_q, carry_d;

  logic [KW-1:0]    k;
  logic             j_lt_n;
  logic             x;
  logic             y;
  logic             sum;
  logic             cout;

  assign j_lt_n = (j_q < C_N);
  assign k      = KW'(i_q) + KW'(j_q);
  assign x      = acc_q[k];
  // The j==N step only flushes the running carry into acc[i+N].
  assign y      = j_lt_n & a_q[j_q[IW-1:0]] & b_q[i_q[IW-1:0]];

  fulladder u_fa (
    .a    (x),
    .b    (y),
    .cin  (carry_q),
    .sum  (sum),
    .cout (cout)
  );

  assign bus.in_ready  = (state_q == S_IDLE) && !rst;
  assign bus.busy      = (state_q == S_ADD);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.p         = p_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    p_d     = p_q;
    i_d     = i_q;
    j_d     = j_q;
    carry_d = carry_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a_in;
          b_d     = bus.b_in;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          carry_d = 1'b0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        acc_d[k +: 1] = sum;
        if (j_lt_n) begin
          carry_d = cout;
          j_d     = j_q + 1'b1;
        end else begin
          carry_d = 1'b0;
          j_d     = '0;
          if (i_q == C_NM1) begin
            p_d     = acc_d;
            state_d = S_DONE;
          end else begin
            i_d = i_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      i_q     <= i_d;
      j_q     <= j_d;
      carry_q <= carry_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_mult_ctrl.sv
// ----------------------------------------------------------------------------
// tb_serial_mult_ctrl: scoreboard bench for the N=4 and N=16 serial multipliers. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_serial_mult_ctrl;
  import mult_pkg::*;

  logic clk = 1'b0;
  logic rst4;
  logic rst16;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic done4 = 1'b0;
  logic done16 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_mult_ctrl_if #(.N(4))  if4 ();
  serial_mult_ctrl_if #(.N(16)) if16 ();

  serial_mult_ctrl #(.N(4)) dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (if4.slave)
  );

  serial_mult_ctrl #(.N(16)) dut16 (
    .clk (clk),
    .rst (rst16),
    .bus (if16.slave)
  );

  typedef struct {
    logic [31:0] p;
    int          acc_cyc;
  } exp_t;

  exp_t q4[$];
  exp_t q16[$];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic [31:0] expp);
    int   n;
    exp_t e;
    n = 0;
    if4.in_valid = 1'b1;
    if4.a_in     = a;
    if4.b_in     = b;
    while (!if4.in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!if4.in_ready) begin
      fail("accept4_timeout");
    end else begin
      e.p       = expp;
      e.acc_cyc = cyc + 1;
      q4.push_back(e);
    end
    @(negedge clk);
    if4.in_valid = 1'b0;
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic [31:0] expp);
    int   n;
    exp_t e;
    n = 0;
    if16.in_valid = 1'b1;
    if16.a_in     = a;
    if16.b_in     = b;
    while (!if16.in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!if16.in_ready) begin
      fail("accept16_timeout");
    end else begin
      e.p       = expp;
      e.acc_cyc = cyc + 1;
      q16.push_back(e);
    end
    @(negedge clk);
    if16.in_valid = 1'b0;
  endtask

  task automatic drain4();
    int n;
    n = 0;
    while (q4.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (q4.size() != 0) fail("drain4_timeout");
  endtask

  task automatic drain16();
    int n;
    n = 0;
    while (q16.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (q16.size() != 0) fail("drain16_timeout");
  endtask

  // Latency counts the accepting edge and the DONE-entry edge inclusively.
  initial begin : mon4
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst4) begin
        q4.delete();
        prev = 1'b0;
      end else begin
        if (if4.out_valid && !prev && q4.size() != 0)
          check("lat4", 64'(cyc - q4[0].acc_cyc + 1), 64'd21);
        if (if4.out_valid && if4.out_ready) begin
          if (q4.size() == 0) begin
            fail("spurious_result4");
          end else begin
            e = q4.pop_front();
            check("p4", 64'(if4.p), 64'(e.p));
          end
        end
        prev = if4.out_valid;
      end
    end
  end

  initial begin : mon16
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst16) begin
        q16.delete();
        prev = 1'b0;
      end else begin
        if (if16.out_valid && !prev && q16.size() != 0)
          check("lat16", 64'(cyc - q16[0].acc_cyc + 1), 64'd273);
        if (if16.out_valid && if16.out_ready) begin
          if (q16.size() == 0) begin
            fail("spurious_result16");
          end else begin
            e = q16.pop_front();
            check("p16", 64'(if16.p), 64'(e.p));
          end
        end
        prev = if16.out_valid;
      end
    end
  end

  // The flush step at j==N must never produce a carry out.
  initial begin : carry_mon
    forever begin
      @(negedge clk);
      if (!rst16 && dut16.state_q == S_ADD && dut16.j_q == 5'd16)
        check("carry16_at_jN", 64'(dut16.cout), 64'd0);
      if (!rst4 && dut4.state_q == S_ADD && dut4.j_q == 3'd4)
        check("carry4_at_jN", 64'(dut4.cout), 64'd0);
    end
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [3:0]  ra4, rb4;
    logic [15:0] ra16, rb16;
    int          n;

    if4.in_valid   = 1'b0;
    if4.a_in       = '0;
    if4.b_in       = '0;
    if4.out_ready  = 1'b1;
    if16.in_valid  = 1'b0;
    if16.a_in      = '0;
    if16.b_in      = '0;
    if16.out_ready = 1'b1;
    rst4  = 1'b1;
    rst16 = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready4", 64'(if4.in_ready), 64'd0);
    check("rst_out_valid4", 64'(if4.out_valid), 64'd0);
    check("rst_busy4", 64'(if4.busy), 64'd0);
    check("rst_p4", 64'(if4.p), 64'd0);
    check("rst_p16", 64'(if16.p), 64'd0);
    @(negedge clk);
    rst4  = 1'b0;
    rst16 = 1'b0;
    #1;
    check("idle_in_ready4", 64'(if4.in_ready), 64'd1);

    send4(4'd15, 4'd15, 32'd225);
    #1;
    check("busy_in_add4", 64'(if4.busy), 64'd1);
    drain4();
    send4(4'd0, 4'd9, 32'd0);
    drain4();
    send4(4'd1, 4'd1, 32'd1);
    drain4();
    send16(16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    drain16();

    // Back-pressure: result held while a competing operand is offered.
    @(negedge clk);
    if4.out_ready = 1'b0;
    send4(4'd13, 4'd11, 32'd143);
    n = 0;
    while (!if4.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!if4.out_valid) fail("bp_wait_out_valid4");
    repeat (10) begin
      @(negedge clk);
      if4.in_valid = 1'b1;
      if4.a_in     = 4'd2;
      if4.b_in     = 4'd2;
      #1;
      check("bp_out_valid4", 64'(if4.out_valid), 64'd1);
      check("bp_p4", 64'(if4.p), 64'd143);
      check("bp_in_ready4", 64'(if4.in_ready), 64'd0);
    end
    @(negedge clk);
    if4.in_valid  = 1'b0;
    if4.out_ready = 1'b1;
    drain4();

    // Reset on the 7th ADD cycle.
    send4(4'd7, 4'd9, 32'd63);
    repeat (6) @(negedge clk);
    #1;
    check("mid_busy4", 64'(if4.busy), 64'd1);
    @(negedge clk);
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    #1;
    check("mid_rst_p4", 64'(if4.p), 64'd0);
    check("mid_rst_out_valid4", 64'(if4.out_valid), 64'd0);
    check("mid_rst_in_ready4", 64'(if4.in_ready), 64'd1);
    check("mid_rst_busy4", 64'(if4.busy), 64'd0);
    send4(4'd3, 4'd5, 32'd15);
    drain4();

    fork
      begin
        for (int t = 0; t < 1000; t++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          ra4 = 4'($urandom);
          rb4 = 4'($urandom);
          send4(ra4, rb4, 32'(ra4) * 32'(rb4));
        end
        done4 = 1'b1;
      end
      begin
        for (int t = 0; t < 150; t++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          ra16 = 16'($urandom);
          rb16 = 16'($urandom);
          send16(ra16, rb16, 32'(ra16) * 32'(rb16));
        end
        done16 = 1'b1;
      end
      begin
        while (!(done4 && done16)) begin
          @(negedge clk);
          if4.out_ready  = ($urandom_range(0, 3) != 0);
          if16.out_ready = ($urandom_range(0, 3) != 0);
        end
        if4.out_ready  = 1'b1;
        if16.out_ready = 1'b1;
      end
    join

    drain4();
    drain16();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
